muldiv_unit: RTL

- Parametrised RV32M/RV64M execution unit for the out-of-order core; replaces the single-cycle-register multiplier.
- Issued from the reservation station with operands and a ROB index. Writes one result per completion to the CDB/ROB.
- MUL/MULH/MULHSU/MULHU run in a pipelined multiplier. DIV/DIVU/REM/REMU run in an iterative radix-2 divider with a valid/ready handshake and flush support.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_divider.sv | 138 +++++++++++++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and helpers for the M-extension unit.
// Holds funct3 encodings, divider FSM state codes and the div/mul decode helper.
package muldiv_pkg;

    typedef logic [2:0] funct3_t;

    localparam funct3_t FUNCT3_MUL    = 3'b000;
    localparam funct3_t FUNCT3_MULH   = 3'b001;
    localparam funct3_t FUNCT3_MULHSU = 3'b010;
    localparam funct3_t FUNCT3_MULHU  = 3'b011;
    localparam funct3_t FUNCT3_DIV    = 3'b100;
    localparam funct3_t FUNCT3_DIVU   = 3'b101;
    localparam funct3_t FUNCT3_REM    = 3'b110;
    localparam funct3_t FUNCT3_REMU   = 3'b111;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_CALC = 2'd1;
    localparam div_state_t DIV_DONE = 2'd2;

    function automatic logic is_div(funct3_t f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue request and writeback bus of the mul/div unit.
// master = issuer/consumer side, slave = muldiv_unit side.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 5
);

    logic                 req_valid_i;
    logic                 req_ready_o;
    funct3_t              funct3_i;
    logic [XLEN-1:0]      rs1_value_i;
    logic [XLEN-1:0]      rs2_value_i;
    logic [ROB_IDX_W-1:0] rob_idx_i;
    logic                 writeback_valid_o;
    logic [XLEN-1:0]      writeback_value_o;
    logic [ROB_IDX_W-1:0] rob_idx_o;

    modport master (
        output req_valid_i, funct3_i, rs1_value_i, rs2_value_i, rob_idx_i,
        input  req_ready_o, writeback_valid_o, writeback_value_o, rob_idx_o
    );

    modport slave (
        input  req_valid_i, funct3_i, rs1_value_i, rs2_value_i, rob_idx_i,
        output req_ready_o, writeback_valid_o, writeback_value_o, rob_idx_o
    );

endinterface

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: clk_i, reset_i, flush_i; start_i + funct3_i/a_i/b_i launch an op;
// busy_o while not idle, done_o for the single result cycle with result_o.
module muldiv_divider
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  funct3_t         funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic            rem_sel_q;

    logic            signed_op;
    logic            rem_sel;
    logic            sa;
    logic            sb;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    always_comb begin
        signed_op = 1'b0;
        rem_sel   = 1'b0;
        unique case (1'b1)
            funct3_i == FUNCT3_DIV:  signed_op = 1'b1;
            funct3_i == FUNCT3_DIVU: ;
            funct3_i == FUNCT3_REM:  begin
                signed_op = 1'b1;
                rem_sel   = 1'b1;
            end
            funct3_i == FUNCT3_REMU: rem_sel = 1'b1;
            default: ;
        endcase
    end

    assign sa       = signed_op & a_i[XLEN-1];
    assign sb       = signed_op & b_i[XLEN-1];
    assign mag_a    = sa ? -a_i : a_i;
    assign mag_b    = sb ? -b_i : b_i;
    assign div_zero = (b_i == '0);
    assign ovf      = signed_op && (a_i == MOST_NEG) && (b_i == '1);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The compare uses
    // XLEN+1 bits; a fitting difference is always below the divisor.
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign fits    = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[XLEN-1:0] - dvs_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        rem_sel_q <= rem_sel;
                        // Special cases skip the iterations; their results
                        // are already final so sign fixup is disabled.
                        if (div_zero) begin
                            quo_q   <= '1;
                            rem_q   <= a_i;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            state_q <= DIV_DONE;
                        end else if (ovf) begin
                            quo_q   <= MOST_NEG;
                            rem_q   <= '0;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            state_q <= DIV_DONE;
                        end else begin
                            quo_q   <= mag_a;
                            rem_q   <= '0;
                            dvs_q   <= mag_b;
                            neg_q_q <= sa ^ sb;
                            neg_r_q <= sa;
                            cnt_q   <= CW'(XLEN);
                            state_q <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    quo_q <= {quo_q[XLEN-2:0], fits};
                    rem_q <= fits ? diff : shifted[XLEN-1:0];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign q_fix    = neg_q_q ? -quo_q : quo_q;
    assign r_fix    = neg_r_q ? -rem_q : rem_q;
    assign result_o = rem_sel_q ? r_fix : q_fix;
    assign busy_o   = (state_q != DIV_IDLE);
    assign done_o   = (state_q == DIV_DONE);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M execution unit (pipelined multiplier + divider).
// Ports: clk_i, reset_i, flush_i; bus (muldiv_if.slave) carries the issue
// handshake (req_*, funct3, operands, rob tag) and the writeback pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ROB_IDX_W  = 5,
    parameter int MUL_STAGES = 2
) (
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     flush_i,
    muldiv_if.slave  bus
);

    typedef struct packed {
        logic                 valid;
        logic                 hi;
        logic [ROB_IDX_W-1:0] tag;
        logic [2*XLEN-1:0]    prod;
    } mul_stage_t;

    logic            op_div;
    logic            accept;
    logic            mul_acc;
    logic            div_acc;
    logic            mul_busy;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    assign op_div  = is_div(bus.funct3_i);
    assign accept  = bus.req_valid_i & bus.req_ready_o;
    assign mul_acc = accept & ~op_div;
    assign div_acc = accept & op_div;

    // A div waits for the mul pipe to drain so the two paths never
    // complete in the same cycle.
    assign bus.req_ready_o = ~flush_i & ~div_busy & ~(op_div & mul_busy);

    logic a_sx;
    logic b_sx;
    logic hi_sel;

    always_comb begin
        a_sx   = 1'b0;
        b_sx   = 1'b0;
        hi_sel = 1'b0;
        unique case (1'b1)
            bus.funct3_i == FUNCT3_MUL:    ;
            bus.funct3_i == FUNCT3_MULH:   begin
                a_sx   = 1'b1;
                b_sx   = 1'b1;
                hi_sel = 1'b1;
            end
            bus.funct3_i == FUNCT3_MULHSU: begin
                a_sx   = 1'b1;
                hi_sel = 1'b1;
            end
            bus.funct3_i == FUNCT3_MULHU:  hi_sel = 1'b1;
            default: ;
        endcase
    end

    // Extending straight to 2*XLEN gives the same low 2*XLEN product bits
    // as an (XLEN+1)-bit signed multiply.
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    mul_stage_t        mul_in;
    mul_stage_t        mul_out;

    assign ext_a = {{XLEN{a_sx & bus.rs1_value_i[XLEN-1]}}, bus.rs1_value_i};
    assign ext_b = {{XLEN{b_sx & bus.rs2_value_i[XLEN-1]}}, bus.rs2_value_i};

    always_comb begin
        mul_in.valid = mul_acc;
        mul_in.hi    = hi_sel;
        mul_in.tag   = bus.rob_idx_i;
        mul_in.prod  = ext_a * ext_b;
    end

    // The writeback register is the final multiplier stage, so only
    // MUL_STAGES-1 internal stages exist.
    if (MUL_STAGES == 1) begin : g_mul_comb
        assign mul_out  = mul_in;
        assign mul_busy = 1'b0;
    end else begin : g_mul_pipe
        mul_stage_t pipe_q [MUL_STAGES-1];

        always_ff @(posedge clk_i) begin
            if (reset_i || flush_i) begin
                for (int i = 0; i < MUL_STAGES - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= mul_in;
                for (int i = 1; i < MUL_STAGES - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        always_comb begin
            mul_busy = 1'b0;
            for (int i = 0; i < MUL_STAGES - 1; i++) begin
                mul_busy = mul_busy | pipe_q[i].valid;
            end
        end

        assign mul_out = pipe_q[MUL_STAGES-2];
    end

    logic [ROB_IDX_W-1:0] div_tag_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_tag_q <= '0;
        end else if (div_acc) begin
            div_tag_q <= bus.rob_idx_i;
        end
    end

    muldiv_divider #(
        .XLEN (XLEN)
    ) u_div (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .flush_i  (flush_i),
        .start_i  (div_acc),
        .funct3_i (bus.funct3_i),
        .a_i      (bus.rs1_value_i),
        .b_i      (bus.rs2_value_i),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .result_o (div_result)
    );

    logic                 wb_valid_q;
    logic [XLEN-1:0]      wb_value_q;
    logic [ROB_IDX_W-1:0] wb_tag_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb_valid_q <= 1'b0;
            wb_value_q <= '0;
            wb_tag_q   <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            if (!flush_i) begin
                if (mul_out.valid) begin
                    wb_valid_q <= 1'b1;
                    wb_value_q <= mul_out.hi ? mul_out.prod[2*XLEN-1:XLEN]
                                             : mul_out.prod[XLEN-1:0];
                    wb_tag_q   <= mul_out.tag;
                end else if (div_done) begin
                    wb_valid_q <= 1'b1;
                    wb_value_q <= div_result;
                    wb_tag_q   <= div_tag_q;
                end
            end
        end
    end

    assign bus.writeback_valid_o = wb_valid_q;
    assign bus.writeback_value_o = wb_value_q;
    assign bus.rob_idx_o         = wb_tag_q;

endmodule
